// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Central stall/flush scheduler for the 5-stage RISC-V pipeline. Every cycle it
// produces one StallBus code (Pass/Hold/Bubb) for the PC register and for each
// of the four pipeline registers. It arbitrates memory-stage waits, EX branch
// mispredicts, ID load-use hazards and fetch misses, keeps a multi-cycle flush
// window while the fetch unit drains, and maintains two saturating
// performance counters.
//
// Parameters:
//   FLUSH_CYCLES  extra IF/ID bubble cycles after a mispredict (0..15, 0 = none)
//   CNT_W         width of the performance counters
//
// Ports:
//   clk           system clock
//   rst           synchronous active-low reset
//   if_busy       fetch not ready this cycle
//   id_rs1_addr   ID source register 1        id_rs1_read  ID reads rs1
//   id_rs2_addr   ID source register 2        id_rs2_read  ID reads rs2
//   ex_rd_addr    rd held in ID/EX            ex_rd_load   ID/EX holds a load
//   branch_error  EX mispredict (level, held while EX is held)
//   mem_start     EX/MEM op in its first MEM cycle
//   mem_done      memory result/ack this cycle
//   stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb
//                 StallBus code per register (combinational, used same edge)
//   stall_cnt     cycles with stall_pc != Pass (saturating)
//   flush_cnt     accepted mispredicts (saturating)
// -----------------------------------------------------------------------------
`ifndef STALL_BUS_DEFS
`define STALL_BUS_DEFS
`define STALL_PASS 2'b00
`define STALL_HOLD 2'b01
`define STALL_BUBB 2'b10
`endif

module pipeline_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_busy,
  input  logic [4:0]       id_rs1_addr,
  input  logic             id_rs1_read,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_rs2_read,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_rd_load,
  input  logic             branch_error,
  input  logic             mem_start,
  input  logic             mem_done,
  output logic [1:0]       stall_pc,
  output logic [1:0]       stall_if_id,
  output logic [1:0]       stall_id_ex,
  output logic [1:0]       stall_ex_mem,
  output logic [1:0]       stall_mem_wb,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Registered state
  state_t           state_r;
  logic             ret_flush_r;   // memory wait was entered from FLUSH
  logic [3:0]       flush_left_r;  // remaining FLUSH cycles, frozen in MEM_WAIT
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Next-state and decoded signals
  state_t     state_s;
  logic       ret_flush_s;
  logic [3:0] flush_left_s;
  logic       lu_s;
  logic       mem_wait_s;
  logic       eff_flush_s;
  logic       br_accept_s;
  logic [1:0] pc_s;
  logic [1:0] if_id_s;
  logic [1:0] id_ex_s;
  logic [1:0] ex_mem_s;
  logic [1:0] mem_wb_s;

  // Load-use hazard: the load in ID/EX writes a register ID is about to read.
  always_comb begin
    lu_s = 1'b0;
    if (ex_rd_load && (ex_rd_addr != 5'd0)) begin
      lu_s = (id_rs1_read && (id_rs1_addr == ex_rd_addr)) ||
             (id_rs2_read && (id_rs2_addr == ex_rd_addr));
    end else begin
      lu_s = 1'b0;
    end
  end

  // A memory wait covers the first MEM cycle and every later cycle up to, but
  // not including, the mem_done cycle.
  assign mem_wait_s = ((state_r == ST_MEM_WAIT) || mem_start) && !mem_done;

  // In the mem_done cycle the controller behaves as the state it came from, so
  // a wait that interrupted FLUSH still counts as flushing here.
  assign eff_flush_s = (state_r == ST_FLUSH) ||
                       ((state_r == ST_MEM_WAIT) && ret_flush_r);

  // Priority arbitration: next state and per-stage stall codes.
  always_comb begin
    state_s      = state_r;
    ret_flush_s  = ret_flush_r;
    flush_left_s = flush_left_r;
    br_accept_s  = 1'b0;
    pc_s         = `STALL_PASS;
    if_id_s      = `STALL_PASS;
    id_ex_s      = `STALL_PASS;
    ex_mem_s     = `STALL_PASS;
    mem_wb_s     = `STALL_PASS;

    if (!rst) begin
      pc_s     = `STALL_BUBB;
      if_id_s  = `STALL_BUBB;
      id_ex_s  = `STALL_BUBB;
      ex_mem_s = `STALL_BUBB;
      mem_wb_s = `STALL_BUBB;
    end else if (mem_wait_s) begin
      // Freeze everything up to EX/MEM; the flush counter is left untouched.
      pc_s        = `STALL_HOLD;
      if_id_s     = `STALL_HOLD;
      id_ex_s     = `STALL_HOLD;
      ex_mem_s    = `STALL_HOLD;
      mem_wb_s    = `STALL_BUBB;
      state_s     = ST_MEM_WAIT;
      ret_flush_s = eff_flush_s;
    end else if (branch_error) begin
      // PC passes so it loads the branch target; younger stages are squashed.
      if_id_s     = `STALL_BUBB;
      id_ex_s     = `STALL_BUBB;
      br_accept_s = 1'b1;
      ret_flush_s = 1'b0;
      if (FLUSH_CYCLES > 0) begin
        state_s      = ST_FLUSH;
        flush_left_s = FLUSH_LOAD;
      end else begin
        state_s      = ST_RUN;
        flush_left_s = 4'd0;
      end
    end else if (eff_flush_s) begin
      // Discard whatever the draining fetch delivers into IF/ID.
      if_id_s     = `STALL_BUBB;
      ret_flush_s = 1'b0;
      if (flush_left_r <= 4'd1) begin
        state_s      = ST_RUN;
        flush_left_s = 4'd0;
      end else begin
        state_s      = ST_FLUSH;
        flush_left_s = flush_left_r - 4'd1;
      end
    end else begin
      state_s      = ST_RUN;
      ret_flush_s  = 1'b0;
      flush_left_s = 4'd0;
      if (lu_s) begin
        pc_s    = `STALL_HOLD;
        if_id_s = `STALL_HOLD;
        id_ex_s = `STALL_BUBB;
      end else if (if_busy) begin
        pc_s    = `STALL_HOLD;
        if_id_s = `STALL_BUBB;
      end else begin
        pc_s    = `STALL_PASS;
        if_id_s = `STALL_PASS;
      end
    end
  end

  // State, flush window and saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_RUN;
      ret_flush_r  <= 1'b0;
      flush_left_r <= 4'd0;
      stall_cnt_r  <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_s;
      ret_flush_r  <= ret_flush_s;
      flush_left_r <= flush_left_s;
      if ((pc_s != `STALL_PASS) && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (br_accept_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_pc     = pc_s;
  assign stall_if_id  = if_id_s;
  assign stall_id_ex  = id_ex_s;
  assign stall_ex_mem = ex_mem_s;
  assign stall_mem_wb = mem_wb_s;
  assign stall_cnt    = stall_cnt_r;
  assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Directed and randomized stimulus for pipeline_stall_ctrl (FLUSH_CYCLES=2,
// CNT_W=4), checked every cycle against a behavioural model that tracks only
// "waiting on memory", "flush cycles left" and the two counters.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_busy;
  logic [4:0]    id_rs1_addr;
  logic          id_rs1_read;
  logic [4:0]    id_rs2_addr;
  logic          id_rs2_read;
  logic [4:0]    ex_rd_addr;
  logic          ex_rd_load;
  logic          branch_error;
  logic          mem_start;
  logic          mem_done;
  logic [1:0]    stall_pc;
  logic [1:0]    stall_if_id;
  logic [1:0]    stall_id_ex;
  logic [1:0]    stall_ex_mem;
  logic [1:0]    stall_mem_wb;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_wait  = 1'b0;
  int m_left  = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_stall_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .if_busy(if_busy),
    .id_rs1_addr(id_rs1_addr), .id_rs1_read(id_rs1_read),
    .id_rs2_addr(id_rs2_addr), .id_rs2_read(id_rs2_read),
    .ex_rd_addr(ex_rd_addr), .ex_rd_load(ex_rd_load),
    .branch_error(branch_error), .mem_start(mem_start), .mem_done(mem_done),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b1; if_busy = 1'b0; branch_error = 1'b0;
    mem_start = 1'b0; mem_done = 1'b0;
    id_rs1_addr = 5'd0; id_rs1_read = 1'b0;
    id_rs2_addr = 5'd0; id_rs2_read = 1'b0;
    ex_rd_addr = 5'd0; ex_rd_load = 1'b0;
  endtask

  task automatic rand_inputs();
    if_busy      = ($urandom_range(99, 0) < 20);
    branch_error = ($urandom_range(99, 0) < 10);
    mem_start    = ($urandom_range(99, 0) < 15);
    mem_done     = ($urandom_range(99, 0) < 40);
    ex_rd_load   = ($urandom_range(99, 0) < 50);
    ex_rd_addr   = 5'($urandom_range(3, 0));
    id_rs1_addr  = 5'($urandom_range(3, 0));
    id_rs2_addr  = 5'($urandom_range(3, 0));
    id_rs1_read  = ($urandom_range(99, 0) < 50);
    id_rs2_read  = ($urandom_range(99, 0) < 50);
  endtask

  // One clock cycle: check codes mid-cycle, then counters after the edge.
  task automatic cyc();
    int  e_pc, e_ifid, e_idex, e_exmem, e_memwb;
    int  n_left, n_stall, n_flush;
    bit  n_wait, lu, mw;
    @(negedge clk);
    #1;
    e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0; e_memwb = 0;
    n_wait = 1'b0; n_left = m_left; n_stall = m_stall; n_flush = m_flush;
    if (!rst) begin
      e_pc = 2; e_ifid = 2; e_idex = 2; e_exmem = 2; e_memwb = 2;
      n_left = 0; n_stall = 0; n_flush = 0;
    end else begin
      lu = ex_rd_load && (ex_rd_addr != 0) &&
           ((id_rs1_read && id_rs1_addr == ex_rd_addr) ||
            (id_rs2_read && id_rs2_addr == ex_rd_addr));
      mw = (m_wait || mem_start) && !mem_done;
      if (mw) begin
        e_pc = 1; e_ifid = 1; e_idex = 1; e_exmem = 1; e_memwb = 2;
        n_wait = 1'b1;
      end else if (branch_error) begin
        e_ifid = 2; e_idex = 2;
        n_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        n_left = FC;
      end else if (m_left > 0) begin
        e_ifid = 2;
        n_left = m_left - 1;
      end else if (lu) begin
        e_pc = 1; e_ifid = 1; e_idex = 2;
      end else if (if_busy) begin
        e_pc = 1; e_ifid = 2;
      end
      if (e_pc != 0) n_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    end
    chk("stall_pc", 32'(stall_pc), 32'(e_pc));
    chk("stall_if_id", 32'(stall_if_id), 32'(e_ifid));
    chk("stall_id_ex", 32'(stall_id_ex), 32'(e_idex));
    chk("stall_ex_mem", 32'(stall_ex_mem), 32'(e_exmem));
    chk("stall_mem_wb", 32'(stall_mem_wb), 32'(e_memwb));
    @(posedge clk);
    #1;
    m_wait = n_wait; m_left = n_left; m_stall = n_stall; m_flush = n_flush;
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs();
      rst = 1'b0;
      cyc();
    end
    idle();
  endtask

  initial begin
    idle();

    // Reset with random inputs, then a clean idle cycle.
    do_reset(3);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    cyc();
    chk("idle_pc_pass", 32'(stall_pc), 32'd0);

    // Load-use on rs2, then the same pattern against x0.
    ex_rd_load = 1'b1; ex_rd_addr = 5'd5; id_rs2_read = 1'b1; id_rs2_addr = 5'd5;
    cyc();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    idle(); cyc();
    ex_rd_load = 1'b1; ex_rd_addr = 5'd0; id_rs2_read = 1'b1; id_rs2_addr = 5'd0;
    cyc();
    chk("lu_x0_stall_cnt", 32'(stall_cnt), 32'd1);
    idle(); cyc();

    // Three-cycle memory wait, then a zero-latency access.
    do_reset(1);
    mem_start = 1'b1; cyc();
    mem_start = 1'b0; cyc(); cyc();
    mem_done = 1'b1; cyc();
    chk("mem_stall_cnt", 32'(stall_cnt), 32'd3);
    idle();
    mem_start = 1'b1; mem_done = 1'b1; cyc();
    chk("mem_zero_lat", 32'(stall_cnt), 32'd3);
    idle(); cyc();

    // Mispredict with a two-cycle flush window.
    do_reset(1);
    branch_error = 1'b1; cyc();
    branch_error = 1'b0; cyc(); cyc(); cyc();
    chk("flush_cnt_one", 32'(flush_cnt), 32'd1);

    // Mispredict while stuck in a memory wait.
    do_reset(1);
    mem_start = 1'b1; cyc();
    mem_start = 1'b0; branch_error = 1'b1; cyc();
    chk("coll_flush_cnt0", 32'(flush_cnt), 32'd0);
    mem_done = 1'b1; cyc();
    chk("coll_flush_cnt1", 32'(flush_cnt), 32'd1);
    idle(); cyc(); cyc(); cyc();

    // Stall counter saturation.
    do_reset(1);
    if_busy = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    chk("stall_sat", 32'(stall_cnt), 32'd15);
    idle(); cyc();

    // Randomized traffic with occasional resets.
    do_reset(1);
    for (int i = 0; i < 800; i++) begin
      rand_inputs();
      rst = ($urandom_range(99, 0) >= 2);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RISC-V pipeline.
- Each cycle, produces one `StallBus` code (`Pass`/`Hold`/`Bubb`) for each of: PC register, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Inputs it arbitrates: memory-stage waits, EX branch mispredicts, ID load-use hazards and fetch misses.
- Keeps a multi-cycle flush window and two performance counters.

Parameters:
- FLUSH_CYCLES, 1: extra IF/ID bubble cycles after a mispredict while the fetch unit drains its outstanding request (0..15; 0 disables the FLUSH state).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset (rst==0 resets on the clk edge)
- if_busy  input  1  fetch not ready this cycle
- id_rs1_addr  input  5  ID source register 1
- id_rs1_read  input  1  ID reads rs1
- id_rs2_addr  input  5  ID source register 2
- id_rs2_read  input  1  ID reads rs2
- ex_rd_addr  input  5  rd held in ID/EX
- ex_rd_load  input  1  ID/EX instruction is a load
- branch_error  input  1  EX mispredict (level; stays valid while EX is held)
- mem_start  input  1  EX/MEM holds a memory op in its first MEM cycle
- mem_done  input  1  memory result/ack this cycle
- stall_pc  output  2  code for the PC register
- stall_if_id  output  2  code for IF/ID
- stall_id_ex  output  2  code for ID/EX
- stall_ex_mem  output  2  code for EX/MEM
- stall_mem_wb  output  2  code for MEM/WB
- stall_cnt  output  CNT_W  cycles with stall_pc != `Pass`
- flush_cnt  output  CNT_W  accepted mispredicts

Behaviour:
- Encoding: `Pass`=2'b00, `Hold`=2'b01, `Bubb`=2'b10 (shared defines).
- Stall outputs are combinational from registered state plus current inputs, so the pipeline registers use them on the same edge. State and counters are registered.
- Reset (rst==0):
  - state=RUN, flush counter=0, stall_cnt=0, flush_cnt=0.
  - All stall outputs = `Bubb` while rst==0.
- States: RUN, MEM_WAIT, FLUSH.
- Load-use hazard: lu = ex_rd_load && ex_rd_addr!=0 && ((id_rs1_read && id_rs1_addr==ex_rd_addr) || (id_rs2_read && id_rs2_addr==ex_rd_addr)).
- Priority (highest first); the named codes apply, all other stages `Pass`:
  1. Memory wait. Condition: (state==MEM_WAIT or mem_start) and !mem_done. Codes: pc, if_id, id_ex, ex_mem = `Hold`; mem_wb = `Bubb`.
  2. branch_error (not in memory wait). Codes: pc `Pass` (loads target), if_id `Bubb`, id_ex `Bubb`. flush_cnt increments. If FLUSH_CYCLES>0: load the flush counter with FLUSH_CYCLES and go to FLUSH.
  3. FLUSH state. Codes: if_id `Bubb`. Counter decrements; return to RUN when it reaches 0 after this cycle. lu is ignored in FLUSH.
  4. lu (RUN only). Codes: pc `Hold`, if_id `Hold`, id_ex `Bubb`.
  5. if_busy. Codes: pc `Hold`, if_id `Bubb`.
- Memory-wait transitions:
  - RUN→MEM_WAIT on mem_start && !mem_done.
  - MEM_WAIT→prior state on mem_done. The mem_done cycle is not a memory-wait cycle; lower priorities apply.
  - mem_start && mem_done in the same cycle: zero-latency access, no stall, no state change.
- Memory wait entered from FLUSH: the flush counter freezes, the FLUSH state is remembered (1-bit return flag), and FLUSH resumes after mem_done.
- branch_error while held in memory wait: not accepted and not counted. It is accepted in the mem_done cycle, since it remains asserted.
- branch_error in FLUSH: accepted again; the counter reloads and flush_cnt increments.
- Counters: saturate at all-ones (no wrap). stall_cnt increments on every non-reset cycle where stall_pc != `Pass`.
- Reset mid-operation: any state, counters and pending flush are cleared on the next edge with rst==0.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs → all five outputs 2'b10; after release stall_cnt=0, flush_cnt=0, all outputs `Pass`.
- Load-use: ex_rd_load=1, ex_rd_addr=5, id_rs2_read=1, id_rs2_addr=5 → pc/if_id `Hold`, id_ex `Bubb` for 1 cycle. Repeat with ex_rd_addr=0 → no stall.
- Memory wait: mem_start pulse, mem_done 3 cycles later → 3 cycles of `Hold` ×4 + mem_wb `Bubb`, then `Pass`; stall_cnt=3. Also mem_start&&mem_done together → no stall.
- Mispredict, FLUSH_CYCLES=2: branch_error for 1 cycle → if_id/id_ex `Bubb` that cycle, then if_id `Bubb` for 2 more cycles; flush_cnt=1.
- Collision: branch_error during memory wait (mem_done 2 cycles later) → flush_cnt stays 0 until the mem_done cycle, then flush codes apply and flush_cnt=1.
- Saturation, CNT_W=4: hold if_busy for 20 cycles → stall_cnt stops at 15.
